// File: rtl/mmio_uart_pkg.sv
// ---------------------------------------------------------------------------
// mmio_uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - bus addresses of the three UART registers (DATA, STATUS, CTRL)
//   - the shifter FSM state encoding
//   - bit positions inside the STATUS read word and the CTRL write word
// No ports; imported by mmio_uart_tx and by its testbench.
// ---------------------------------------------------------------------------
package mmio_uart_pkg;

   localparam logic [31:0] UART_DATA_ADDR   = 32'hffff_0080;
   localparam logic [31:0] UART_STATUS_ADDR = 32'hffff_0084;
   localparam logic [31:0] UART_CTRL_ADDR   = 32'hffff_0088;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } txState_e;

   localparam int STAT_FULL      = 0;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_COUNT_LSB = 3;
   localparam int STAT_COUNT_W   = 3;
   localparam int STAT_IE        = 8;
   localparam int STAT_PENDING   = 9;
   localparam int STAT_OVF       = 10;

   localparam int CTRL_IE      = 0;
   localparam int CTRL_ACK     = 1;
   localparam int CTRL_OVF_CLR = 2;

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Small synchronous FIFO of 8-bit entries used to queue bytes for the UART
// shifter. FIFO_DEPTH must be a power of two (at least 2) so the pointers
// wrap naturally.
// Ports:
//   clk, reset      clock and synchronous active-high reset (empties FIFO)
//   push_i          write pushData_i; ignored while full
//   pushData_i      byte to enqueue
//   pop_i           remove the head entry; ignored while empty
//   popData_o       head entry (valid while not empty)
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries
// ---------------------------------------------------------------------------
module byte_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push_i,
   input  logic [7:0]                  pushData_i,
   input  logic                        pop_i,
   output logic [7:0]                  popData_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [$clog2(FIFO_DEPTH):0] count_o
);

   localparam int PW = $clog2(FIFO_DEPTH);

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wrPtr_q;
   logic [PW-1:0] rdPtr_q;
   logic [PW:0]   count_q;
   logic          doPush;
   logic          doPop;

   // Accepted operations: fullness and emptiness are the pre-edge values, so
   // a pop in the same cycle never makes room for a push into a full FIFO.
   always_comb begin
      doPush = push_i && !full_o;
      doPop  = pop_i && !empty_o;
   end

   // Pointer and occupancy bookkeeping. Pointers wrap modulo the depth; the
   // count carries one extra bit so "full" and "empty" are distinguishable.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         if (doPush && !doPop) begin
            count_q <= count_q + 1'b1;
         end else if (doPop && !doPush) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // Storage array. Contents need no reset because the count gates validity.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

   // Flags and head-of-queue data are plain decodes of the registers.
   always_comb begin
      full_o    = (count_q == (PW + 1)'(FIFO_DEPTH));
      empty_o   = (count_q == '0);
      count_o   = count_q;
      popData_o = mem_q[rdPtr_q];
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped 8N1 serial transmitter for the single-cycle MIPS data bus.
// The CPU stores bytes to DATA, they are queued in a small FIFO and shifted
// out LSB first on tx. A level interrupt (TxInterrupt) can be raised once the
// FIFO and shifter have fully drained.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   TxInterrupt   interrupt request to cp0 (level, held until acknowledged)
//   cpu_readData  combinational load data (STATUS only, else 0)
//   UartAddress   combinational "address hits a UART register" flag, used to
//                 mask data memory enables
//   data          store data from the CPU
//   address       effective address from the ALU
//   MemRead       load strobe
//   MemWrite      store strobe
//   tx            serial output, idles high
// ---------------------------------------------------------------------------
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        TxInterrupt,
   output logic [31:0] cpu_readData,
   output logic        UartAddress,
   input  logic [31:0] data,
   input  logic [31:0] address,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic        tx
);

   localparam int            BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   txState_e                  state_q, state_d;
   logic [BW-1:0]             baudCnt_q, baudCnt_d;
   logic [2:0]                bitCnt_q, bitCnt_d;
   logic [7:0]                shift_q, shift_d;
   logic                      ie_q, ie_d;
   logic                      pending_q, pending_d;
   logic                      ovf_q, ovf_d;

   logic                      hitData, hitStatus, hitCtrl;
   logic                      dataWrite, ctrlWrite;
   logic                      baudLast;
   logic                      pop;
   logic                      busy;
   logic                      setPending;
   logic                      fifoFull, fifoEmpty;
   logic [7:0]                fifoData;
   logic [$clog2(FIFO_DEPTH):0] fifoCount;
   logic [31:0]               status;
   logic                      unusedBits;

   assign unusedBits = ^data[31:8];

   byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (dataWrite),
      .pushData_i (data[7:0]),
      .pop_i      (pop),
      .popData_o  (fifoData),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty),
      .count_o    (fifoCount)
   );

   // Address decode. UartAddress depends on the address alone so the CPU can
   // use it to steer both loads and stores away from data memory.
   always_comb begin
      hitData     = (address == UART_DATA_ADDR);
      hitStatus   = (address == UART_STATUS_ADDR);
      hitCtrl     = (address == UART_CTRL_ADDR);
      UartAddress = hitData || hitStatus || hitCtrl;
      dataWrite   = MemWrite && hitData;
      ctrlWrite   = MemWrite && hitCtrl;
   end

   // STATUS word assembly and the single-cycle load path. Only STATUS is
   // readable; DATA and CTRL read back as zero.
   always_comb begin
      status                                 = '0;
      status[STAT_FULL]                      = fifoFull;
      status[STAT_EMPTY]                     = fifoEmpty;
      status[STAT_BUSY]                      = busy;
      status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifoCount);
      status[STAT_IE]                        = ie_q;
      status[STAT_PENDING]                   = pending_q;
      status[STAT_OVF]                       = ovf_q;
      cpu_readData = (MemRead && hitStatus) ? status : 32'h0;
   end

   // State register for the shifter FSM together with its datapath and the
   // control registers; everything returns to idle on reset, which also
   // abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         baudCnt_q <= '0;
         bitCnt_q  <= '0;
         shift_q   <= '0;
         ie_q      <= 1'b0;
         pending_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         baudCnt_q <= baudCnt_d;
         bitCnt_q  <= bitCnt_d;
         shift_q   <= shift_d;
         ie_q      <= ie_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   // Next-state logic. Every non-idle phase lasts a whole number of baud
   // periods; STOP chains straight into the next START when bytes are queued
   // so back-to-back frames have no idle gap.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifoEmpty) state_d = START;
         START:   if (baudLast) state_d = DATA;
         DATA:    if (baudLast && (bitCnt_q == 3'd7)) state_d = STOP;
         STOP:    if (baudLast) state_d = fifoEmpty ? IDLE : START;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: line level, busy flag, FIFO pop request and the interrupt
   // set condition (frame just ended and nothing left to send).
   always_comb begin
      baudLast   = (baudCnt_q == BAUD_LAST);
      busy       = (state_q != IDLE);
      pop        = !fifoEmpty && ((state_q == IDLE) || ((state_q == STOP) && baudLast));
      setPending = (state_q == STOP) && baudLast && fifoEmpty && ie_q;
      case (state_q)
         START:   tx = 1'b0;
         DATA:    tx = shift_q[0];
         default: tx = 1'b1;
      endcase
   end

   // Shifter datapath: the baud counter free-runs while a frame is active,
   // a pop loads a fresh byte, and each completed data bit shifts right.
   always_comb begin
      baudCnt_d = baudCnt_q;
      bitCnt_d  = bitCnt_q;
      shift_d   = shift_q;
      if (state_q == IDLE || baudLast) begin
         baudCnt_d = '0;
      end else begin
         baudCnt_d = baudCnt_q + 1'b1;
      end
      if (pop) begin
         shift_d  = fifoData;
         bitCnt_d = '0;
      end else if ((state_q == DATA) && baudLast) begin
         shift_d  = {1'b0, shift_q[7:1]};
         bitCnt_d = bitCnt_q + 3'd1;
      end
   end

   // Control registers. For both sticky flags a hardware set in the same
   // cycle as a software clear wins, so no event is ever lost.
   always_comb begin
      ie_d      = ie_q;
      pending_d = pending_q;
      ovf_d     = ovf_q;
      if (ctrlWrite) begin
         ie_d = data[CTRL_IE];
      end
      if (setPending) begin
         pending_d = 1'b1;
      end else if (ctrlWrite && data[CTRL_ACK]) begin
         pending_d = 1'b0;
      end
      if (dataWrite && fifoFull) begin
         ovf_d = 1'b1;
      end else if (ctrlWrite && data[CTRL_OVF_CLR]) begin
         ovf_d = 1'b0;
      end
      TxInterrupt = pending_q;
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
// Self-checking bench for mmio_uart_tx: a decode vector table, a serial-line
// monitor that reassembles frames and checks them against a queue of
// expected bytes, and hand-written sequences for the multi-cycle cases.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;
   import mmio_uart_pkg::*;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;
   localparam int NV    = 10;

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [31:0] wdata;
      logic        expUa;
      logic [31:0] expRd;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] data = 32'h0;
   logic [31:0] address = 32'h0;
   logic        tx;
   logic        TxInterrupt;
   logic        UartAddress;
   logic [31:0] cpu_readData;

   int          errors = 0;
   int          checks = 0;
   int          cycleCnt = 0;
   int          resetCnt = 0;
   int          frameCount = 0;
   logic [7:0]  expQ[$];
   int          frameStarts[$];
   vec_t        vecs[NV];

   mmio_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .TxInterrupt  (TxInterrupt),
      .cpu_readData (cpu_readData),
      .UartAddress  (UartAddress),
      .data         (data),
      .address      (address),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .tx           (tx)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Edge bookkeeping: number of rising edges so far, and how many of them
   // saw reset asserted (lets the monitor notice a reset mid-frame).
   always @(posedge clk) begin
      cycleCnt++;
      if (reset) resetCnt++;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr, input logic [31:0] wdata);
      address  = addr;
      MemRead  = rd;
      MemWrite = wr;
      data     = wdata;
   endtask

   // Store that commits on the next rising edge; returns at the following
   // falling edge with the bus idle.
   task automatic busWrite(input logic [31:0] addr, input logic [31:0] wdata);
      applyStimulus(addr, 1'b0, 1'b1, wdata);
      @(negedge clk);
      applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic checkStatus(input string name, input logic [31:0] expected);
      logic [31:0] v;
      applyStimulus(UART_STATUS_ADDR, 1'b1, 1'b0, 32'h0);
      #1;
      v = cpu_readData;
      applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput(name, v, expected);
   endtask

   task automatic waitForCycle(input int c);
      while (cycleCnt < c) @(negedge clk);
   endtask

   // Serial monitor: on a low start level, follow the whole frame cycle by
   // cycle, rebuild the byte and compare it with the oldest expected byte.
   initial begin : txMonitor
      logic [7:0] got;
      logic       shapeOk;
      logic       aborted;
      int         startCyc;
      int         rstMark;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            startCyc = cycleCnt;
            rstMark  = resetCnt;
            shapeOk  = 1'b1;
            aborted  = 1'b0;
            got      = 8'h0;
            for (int c = 1; c < FRAME; c++) begin
               @(negedge clk);
               if (resetCnt != rstMark) begin
                  aborted = 1'b1;
                  break;
               end
               if (c < CPB) begin
                  if (tx !== 1'b0) shapeOk = 1'b0;
               end else if (c < 9 * CPB) begin
                  if ((c % CPB) == 0) got[(c / CPB) - 1] = tx;
                  else if (tx !== got[(c / CPB) - 1]) shapeOk = 1'b0;
               end else begin
                  if (tx !== 1'b1) shapeOk = 1'b0;
               end
            end
            if (!aborted) begin
               frameCount++;
               frameStarts.push_back(startCyc);
               checkOutput("frame_shape", {31'h0, shapeOk}, 32'h1);
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL frame_unexpected: got byte 0x%02h, expected no frame", got);
               end else begin
                  checkOutput("frame_byte", {24'h0, got}, {24'h0, expQ.pop_front()});
               end
            end
         end
      end
   end

   // Hard stop in case something never returns.
   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "[TB] simulation timeout");
   end

   // Main stimulus sequence.
   initial begin : stim
      int w;
      int base;

      vecs[0] = '{UART_STATUS_ADDR, 1'b1, 1'b0, 32'h0,   1'b1, 32'h2};
      vecs[1] = '{UART_DATA_ADDR,   1'b1, 1'b0, 32'h0,   1'b1, 32'h0};
      vecs[2] = '{UART_CTRL_ADDR,   1'b1, 1'b0, 32'h0,   1'b1, 32'h0};
      vecs[3] = '{32'hffff_0090,    1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
      vecs[4] = '{32'hffff_0090,    1'b0, 1'b1, 32'h77,  1'b0, 32'h0};
      vecs[5] = '{UART_STATUS_ADDR, 1'b1, 1'b0, 32'h0,   1'b1, 32'h2};
      vecs[6] = '{UART_STATUS_ADDR, 1'b0, 1'b1, 32'h1ff, 1'b1, 32'h0};
      vecs[7] = '{UART_STATUS_ADDR, 1'b1, 1'b0, 32'h0,   1'b1, 32'h2};
      vecs[8] = '{32'hffff_0081,    1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
      vecs[9] = '{32'h0000_0084,    1'b1, 1'b0, 32'h0,   1'b0, 32'h0};

      applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("[TB] reset released");
      checkOutput("reset_tx", {31'h0, tx}, 32'h1);
      checkOutput("reset_irq", {31'h0, TxInterrupt}, 32'h0);

      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata);
         #1;
         checkOutput($sformatf("vec%0d_uartaddr", i), {31'h0, UartAddress}, {31'h0, vecs[i].expUa});
         checkOutput($sformatf("vec%0d_readdata", i), cpu_readData, vecs[i].expRd);
         @(negedge clk);
      end
      applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("tx_idle_after_decode", {31'h0, tx}, 32'h1);

      $display("[TB] single byte 0x55");
      w = cycleCnt + 1;
      expQ.push_back(8'h55);
      busWrite(UART_DATA_ADDR, 32'h55);
      checkStatus("push_visible", 32'h08);
      checkOutput("tx_before_pop", {31'h0, tx}, 32'h1);
      waitForCycle(w + 1);
      checkOutput("tx_start_low", {31'h0, tx}, 32'h0);
      checkStatus("busy_after_pop", 32'h06);
      waitForCycle(w + FRAME);
      checkStatus("busy_last_cycle", 32'h06);
      waitForCycle(w + 1 + FRAME);
      checkStatus("busy_cleared", 32'h02);
      checkOutput("single_frames", frameCount, 1);
      if (frameStarts.size() > 0) checkOutput("single_start_cycle", frameStarts[0], w + 1);
      checkOutput("no_irq_ie0", {31'h0, TxInterrupt}, 32'h0);

      $display("[TB] burst of six writes");
      frameStarts.delete();
      w = cycleCnt + 1;
      for (int i = 1; i <= 6; i++) begin
         if (i <= 5) expQ.push_back(8'(i));
         busWrite(UART_DATA_ADDR, 32'(i));
      end
      checkStatus("full_after_burst", 32'h425);
      waitForCycle(w + 2 + 5 * FRAME);
      checkOutput("burst_frames", frameStarts.size(), 5);
      if (frameStarts.size() > 0) checkOutput("burst_first_start", frameStarts[0], w + 1);
      for (int i = 1; i < frameStarts.size(); i++) begin
         checkOutput($sformatf("burst_gap%0d", i), frameStarts[i] - frameStarts[i - 1], FRAME);
      end
      checkStatus("ovf_sticky", 32'h402);
      busWrite(UART_CTRL_ADDR, 32'h4);
      checkStatus("ovf_cleared", 32'h002);

      $display("[TB] interrupt on drain");
      busWrite(UART_CTRL_ADDR, 32'h1);
      checkStatus("ie_set", 32'h102);
      w = cycleCnt + 1;
      expQ.push_back(8'hA5);
      busWrite(UART_DATA_ADDR, 32'hA5);
      waitForCycle(w + FRAME);
      checkOutput("irq_before_stop_end", {31'h0, TxInterrupt}, 32'h0);
      waitForCycle(w + FRAME + 1);
      checkOutput("irq_raised", {31'h0, TxInterrupt}, 32'h1);
      checkStatus("status_pending", 32'h302);
      busWrite(UART_CTRL_ADDR, 32'h3);
      checkOutput("irq_acked", {31'h0, TxInterrupt}, 32'h0);
      checkStatus("ie_kept", 32'h102);

      $display("[TB] set and clear in the same cycle");
      w = cycleCnt + 1;
      expQ.push_back(8'h3C);
      busWrite(UART_DATA_ADDR, 32'h3C);
      waitForCycle(w + FRAME);
      busWrite(UART_CTRL_ADDR, 32'h3);
      checkOutput("set_beats_clear", {31'h0, TxInterrupt}, 32'h1);
      busWrite(UART_CTRL_ADDR, 32'h2);
      checkOutput("irq_cleared", {31'h0, TxInterrupt}, 32'h0);
      checkStatus("ie_off", 32'h002);

      $display("[TB] reset mid-frame");
      w = cycleCnt + 1;
      busWrite(UART_DATA_ADDR, 32'h11);
      busWrite(UART_DATA_ADDR, 32'h22);
      busWrite(UART_DATA_ADDR, 32'h33);
      waitForCycle(w + 1 + 10);
      checkStatus("queued_before_reset", 32'h14);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("reset_tx_high", {31'h0, tx}, 32'h1);
      checkStatus("reset_status", 32'h2);
      base = frameCount;
      waitForCycle(cycleCnt + 3 * FRAME);
      checkOutput("no_frame_after_reset", frameCount, base);
      checkOutput("tx_idle_after_reset", {31'h0, tx}, 32'h1);
      checkStatus("still_empty", 32'h2);

      checkOutput("exp_queue_drained", expQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
